// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a small program memory and hands one
// command at a time to a downstream ALU/regfile, waiting for its completion.
module instr_sequencer #(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_wdata,
  input  logic [LW-1:0] prog_len,
  input  logic          run,
  input  logic          abort,
  input  logic          cmd_done,
  input  logic          z_flag_in,
  input  logic          c_flag_in,
  output logic          start_cmd,
  output logic [2:0]    op_out,
  output logic [2:0]    rd_out,
  output logic [2:0]    rs1_out,
  output logic [2:0]    rs2_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] pc,
  output logic          z_flag,
  output logic          c_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [11:0]   r_mem [DEPTH];
  logic [LW-1:0] r_pc;
  logic [LW-1:0] r_len;
  logic [CW-1:0] r_wcnt;
  logic          r_z;
  logic          r_c;
  logic [11:0]   r_hold;

  logic          w_idle_like;
  logic          w_start;
  logic [LW-1:0] w_len_sat;
  logic [LW-1:0] w_pc_inc;
  logic          w_timeout;
  logic [11:0]   w_word;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_start     = w_idle_like && run && !abort;
  assign w_len_sat   = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign w_pc_inc    = r_pc + LW'(1);
  assign w_timeout   = (r_wcnt == CW'(TIMEOUT - 1));
  assign w_word      = r_mem[r_pc[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR:
          if (run) w_next = (w_len_sat == '0) ? S_DONE : S_ISSUE;
        S_ISSUE:
          w_next = S_WAIT;
        S_WAIT:
          if (cmd_done)       w_next = (w_pc_inc == r_len) ? S_DONE : S_ISSUE;
          else if (w_timeout) w_next = S_ERROR;
        default:
          w_next = S_IDLE;
      endcase
    end
  end

  // Abort freezes pc and flags in place; only the state returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_len <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
    end else if (!abort) begin
      if (w_start) begin
        r_len <= w_len_sat;
        r_pc  <= '0;
      end else if (r_state == S_WAIT && cmd_done) begin
        r_pc <= w_pc_inc;
        r_z  <= z_flag_in;
        r_c  <= c_flag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_wcnt <= '0;
    else if (r_state == S_ISSUE)                  r_wcnt <= '0;
    else if (r_state == S_WAIT && !cmd_done && !w_timeout) r_wcnt <= r_wcnt + CW'(1);
  end

  // Fields are shown live from memory during ISSUE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_hold <= '0;
    else if (r_state == S_ISSUE) r_hold <= w_word;
  end

  always_ff @(posedge clk) begin
    if (prog_we && w_idle_like) r_mem[prog_addr] <= prog_wdata;
  end

  assign start_cmd = (r_state == S_ISSUE);
  assign {op_out, rd_out, rs1_out, rs2_out} = (r_state == S_ISSUE) ? w_word : r_hold;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERROR);
  assign pc        = r_pc;
  assign z_flag    = r_z;
  assign c_flag    = r_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: table of short programs plus hand-written
// sequences for timeout, abort, reset in WAIT, write/run overlap and saturation.
module tb_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [11:0]   prog_wdata;
  logic [LW-1:0] prog_len;
  logic          run, abort, cmd_done, z_flag_in, c_flag_in;
  logic          start_cmd;
  logic [2:0]    op_out, rd_out, rs1_out, rs2_out;
  logic          busy, done, err;
  logic [LW-1:0] pc;
  logic          z_flag, c_flag;

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .run(run), .abort(abort),
    .cmd_done(cmd_done), .z_flag_in(z_flag_in), .c_flag_in(c_flag_in),
    .start_cmd(start_cmd), .op_out(op_out), .rd_out(rd_out), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .busy(busy), .done(done), .err(err), .pc(pc),
    .z_flag(z_flag), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0][11:0] w;
    int               len;
    int               lat;
    bit               zin, cin;
    int               exp_pulses;
    logic [11:0]      exp_last;
    int               exp_pc;
    int               exp_gap;
    bit               exp_z, exp_c;
  } vec_t;

  vec_t v [4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [11:0] word);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_wdata = word;
    step();
    prog_we = 1'b0;
  endtask

  function automatic logic [11:0] fields();
    return {op_out, rd_out, rs1_out, rs2_out};
  endfunction

  // Pulse run, then act as the downstream unit answering lat cycles into WAIT.
  task automatic exec(input int len, input int lat, input bit zin, input bit cin,
                      output int pulses, output int gap, output logic [11:0] last,
                      output int ncyc);
    int prev, wc, cyc;
    pulses = 0; gap = 0; last = '0; prev = -1; wc = 0;
    prog_len = LW'(len); run = 1'b1;
    step();
    run = 1'b0; prog_we = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (start_cmd) begin
        pulses++; last = fields();
        if (prev >= 0) gap = cyc - prev;
        prev = cyc; wc = 0; cmd_done = 1'b0;
      end else if (busy) begin
        wc++;
        cmd_done = (wc == lat); z_flag_in = zin; c_flag_in = cin;
      end else begin
        cmd_done = 1'b0;
        break;
      end
      step();
    end
    ncyc = cyc;
    if (cyc == 400) chk("exec_bound", 0, 1);
  endtask

  // A few idle cycles after completion: no stray strobe, state and flags held.
  task automatic post(input string tag, input bit exp_done, input bit exp_err,
                      input bit ez, input bit ec);
    int extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (start_cmd) extra++;
      step();
    end
    chk({tag, "_extra_start"}, extra, 0);
    chk({tag, "_done_hold"}, done, exp_done);
    chk({tag, "_err_hold"}, err, exp_err);
    chk({tag, "_z_hold"}, z_flag, ez);
    chk({tag, "_c_hold"}, c_flag, ec);
  endtask

  initial begin
    int          pulses, gap, ncyc;
    logic [11:0] last;

    // ADD=0, SUB=1, MOV=7
    v[0] = '{w: {12'h000, 12'h000, 12'h000, 12'h10A}, len: 1, lat: 3, zin: 0, cin: 0,
             exp_pulses: 1, exp_last: 12'h10A, exp_pc: 1, exp_gap: 0, exp_z: 0, exp_c: 0};
    v[1] = '{w: {12'hE40, 12'h4C8, 12'h2D3, 12'h10A}, len: 4, lat: 1, zin: 0, cin: 1,
             exp_pulses: 4, exp_last: 12'hE40, exp_pc: 4, exp_gap: 2, exp_z: 0, exp_c: 1};
    v[2] = '{w: {12'h000, 12'h000, 12'h000, 12'h2D3}, len: 1, lat: 2, zin: 1, cin: 0,
             exp_pulses: 1, exp_last: 12'h2D3, exp_pc: 1, exp_gap: 0, exp_z: 1, exp_c: 0};
    v[3] = '{w: {12'h000, 12'h655, 12'h3C1, 12'h0F7}, len: 3, lat: 2, zin: 1, cin: 1,
             exp_pulses: 3, exp_last: 12'h655, exp_pc: 3, exp_gap: 3, exp_z: 1, exp_c: 1};

    rst_n = 1'b0; prog_we = 0; prog_addr = '0; prog_wdata = '0; prog_len = '0;
    run = 0; abort = 0; cmd_done = 0; z_flag_in = 0; c_flag_in = 0;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_start", start_cmd, 0);
    chk("rst_fields", fields(), 0);
    chk("rst_status", {busy, done, err, z_flag, c_flag}, 0);
    rst_n = 1'b1;
    step();

    foreach (v[i]) begin
      for (int a = 0; a < v[i].len && a < 4; a++) load(a, v[i].w[a]);
      exec(v[i].len, v[i].lat, v[i].zin, v[i].cin, pulses, gap, last, ncyc);
      chk($sformatf("v%0d_pulses", i), pulses, v[i].exp_pulses);
      chk($sformatf("v%0d_last", i), last, v[i].exp_last);
      chk($sformatf("v%0d_fields_held", i), fields(), v[i].exp_last);
      chk($sformatf("v%0d_pc", i), pc, v[i].exp_pc);
      chk($sformatf("v%0d_done", i), done, 1);
      if (v[i].exp_gap != 0) chk($sformatf("v%0d_gap", i), gap, v[i].exp_gap);
      post($sformatf("v%0d", i), 1'b1, 1'b0, v[i].exp_z, v[i].exp_c);
    end

    // prog_len=0: DONE right after the run edge, no strobe.
    exec(0, 1, 0, 0, pulses, gap, last, ncyc);
    chk("len0_pulses", pulses, 0);
    chk("len0_cycles", ncyc, 0);
    chk("len0_done", done, 1);
    chk("len0_pc", pc, 0);

    // Timeout: cmd_done withheld; err appears TIMEOUT cycles after WAIT entry.
    load(0, 12'h10A);
    exec(2, 10000, 0, 0, pulses, gap, last, ncyc);
    chk("to_pulses", pulses, 1);
    chk("to_wait_cycles", ncyc - 1, TIMEOUT);
    chk("to_err", err, 1);
    chk("to_pc", pc, 0);
    post("to", 1'b0, 1'b1, 1'b1, 1'b1);

    // Abort in WAIT; writes during busy dropped; run during busy ignored.
    load(0, 12'h0CA);
    load(1, 12'h5AB);
    prog_len = LW'(2); run = 1'b1;
    step();
    run = 1'b0;
    chk("ab_start0", start_cmd, 1);
    prog_we = 1'b1; prog_addr = AW'(1); prog_wdata = 12'hFFF;
    step();
    prog_we = 1'b0;
    cmd_done = 1'b1; z_flag_in = 1'b0; c_flag_in = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("ab_start1", start_cmd, 1);
    chk("ab_mem_kept", fields(), 12'h5AB);
    chk("ab_pc1", pc, 1);
    step();
    prog_len = '0; run = 1'b1;
    step();
    run = 1'b0;
    chk("ab_run_ignored", {busy, done}, 2'b10);
    chk("ab_run_pc", pc, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle", {busy, done, err}, 0);
    chk("ab_pc_kept", pc, 1);
    chk("ab_flags", {z_flag, c_flag}, 2'b01);
    cmd_done = 1'b1; z_flag_in = 1'b1; c_flag_in = 1'b0;
    step();
    cmd_done = 1'b0;
    chk("ab_late_done_flags", {z_flag, c_flag}, 2'b01);
    chk("ab_late_done_state", {start_cmd, busy, done, err}, 0);
    chk("ab_late_done_pc", pc, 1);

    // Write and run in the same cycle execute the new word.
    prog_we = 1'b1; prog_addr = '0; prog_wdata = 12'h3F1;
    exec(1, 1, 0, 1, pulses, gap, last, ncyc);
    chk("wr_run_last", last, 12'h3F1);
    chk("wr_run_pulses", pulses, 1);

    // Asynchronous reset in the middle of WAIT with cmd_done pending.
    prog_len = LW'(1); run = 1'b1;
    step();
    run = 1'b0;
    step();
    chk("rw_in_wait", {start_cmd, busy}, 2'b01);
    cmd_done = 1'b1; z_flag_in = 1'b1; c_flag_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rw_pc", pc, 0);
    chk("rw_status", {start_cmd, busy, done, err, z_flag, c_flag}, 0);
    chk("rw_fields", fields(), 0);
    step();
    cmd_done = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rw_no_flag_update", {z_flag, c_flag}, 0);
    exec(1, 1, 0, 0, pulses, gap, last, ncyc);
    chk("rw_mem_retained", last, 12'h3F1);

    // prog_len above DEPTH saturates to a full-memory run.
    for (int a = 0; a < DEPTH; a++) load(a, 12'(a * 37 + 5));
    exec(DEPTH + 4, 1, 1, 0, pulses, gap, last, ncyc);
    chk("sat_pulses", pulses, DEPTH);
    chk("sat_pc", pc, DEPTH);
    chk("sat_last", last, 12'((DEPTH - 1) * 37 + 5));
    chk("sat_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
